// File: rtl/ser_xmt.sv
// ser_xmt: serial line transmitter, byte FIFO in, async 8N1 frames out.
// Optional even parity bit when SER_XMT_PARITY_EN is defined (8E1).
//
// Parameters:
//   DEPTH      FIFO entries, power of two, >= 2
//   DEPTH_LG   log2(DEPTH), pointer width
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active-high
//   bit_len     clocks per serial bit, latched at each frame start (0 -> 1)
//   write       one-cycle strobe, push data_in when ready=1
//   data_in     byte to transmit
//   ready       FIFO not full (registered)
//   idle        FIFO empty and no frame on the line (registered)
//   serial_out  txd line, idle high (registered)
// Macro: SER_XMT_PARITY_EN adds a PARITY state between DATA and STOP.

module ser_xmt #(
  parameter int DEPTH    = 4,
  parameter int DEPTH_LG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bit_len,
  input  logic        write,
  input  logic [7:0]  data_in,
  output logic        ready,
  output logic        idle,
  output logic        serial_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SER_XMT_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [DEPTH_LG:0] FULL = (DEPTH_LG + 1)'(DEPTH);
  localparam logic [DEPTH_LG:0] CNT1 = (DEPTH_LG + 1)'(1);

  // FIFO storage and bookkeeping
  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LG-1:0] wr_ptr;
  logic [DEPTH_LG-1:0] rd_ptr;
  logic [DEPTH_LG:0]   count;
  logic [DEPTH_LG:0]   count_n;
  logic                push;
  logic                pop;
  logic [7:0]          head;

  // engine state
  state_t      state;
  state_t      state_n;
  logic [7:0]  shift;
  logic [7:0]  shift_n;
  logic [2:0]  idx;
  logic [2:0]  idx_n;
  logic [15:0] tmr;
  logic [15:0] tmr_n;
  logic [15:0] len_m1;
  logic [15:0] len_m1_n;
  logic [15:0] ld_len;
  logic        tmr_end;
  logic        has_data;
  logic        line;

`ifdef SER_XMT_PARITY_EN
  logic        par;
  logic        par_n;
`endif

  // ready mirrors (count != DEPTH), so it gates writes directly
  assign push     = write & ready;
  assign head     = mem[rd_ptr];
  assign has_data = (count != '0);
  assign tmr_end  = (tmr == '0);

  // bit time for the next frame; 0 behaves like 1
  assign ld_len = (bit_len == '0) ? 16'd0
                                  : bit_len - 16'd1;

  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CNT1;
      2'b01:   count_n = count - CNT1;
      default: count_n = count;
    endcase
  end

  // next-state and datapath decode
  always_comb begin
    state_n  = state;
    shift_n  = shift;
    idx_n    = idx;
    tmr_n    = tmr;
    len_m1_n = len_m1;
    pop      = 1'b0;
`ifdef SER_XMT_PARITY_EN
    par_n    = par;
`endif
    unique case (state)
      S_IDLE: begin
        if (has_data) begin
          pop      = 1'b1;
          shift_n  = head;
          len_m1_n = ld_len;
          tmr_n    = ld_len;
          state_n  = S_START;
`ifdef SER_XMT_PARITY_EN
          par_n    = ^head;
`endif
        end
      end
      S_START: begin
        if (tmr_end) begin
          tmr_n   = len_m1;
          idx_n   = 3'd0;
          state_n = S_DATA;
        end else begin
          tmr_n = tmr - 16'd1;
        end
      end
      S_DATA: begin
        if (tmr_end) begin
          tmr_n = len_m1;
          if (idx == 3'd7) begin
`ifdef SER_XMT_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            shift_n = {1'b0, shift[7:1]};
            idx_n   = idx + 3'd1;
          end
        end else begin
          tmr_n = tmr - 16'd1;
        end
      end
`ifdef SER_XMT_PARITY_EN
      S_PARITY: begin
        if (tmr_end) begin
          tmr_n   = len_m1;
          state_n = S_STOP;
        end else begin
          tmr_n = tmr - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (tmr_end) begin
          if (has_data) begin
            // chain straight into the next frame, no idle gap
            pop      = 1'b1;
            shift_n  = head;
            len_m1_n = ld_len;
            tmr_n    = ld_len;
            state_n  = S_START;
`ifdef SER_XMT_PARITY_EN
            par_n    = ^head;
`endif
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          tmr_n = tmr - 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // line level for the current state, registered one cycle later
  always_comb begin
    line = 1'b1;
    unique case (state)
      S_START:  line = 1'b0;
      S_DATA:   line = shift[0];
`ifdef SER_XMT_PARITY_EN
      S_PARITY: line = par;
`endif
      default:  line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      shift      <= '0;
      idx        <= '0;
      tmr        <= '0;
      len_m1     <= '0;
      ready      <= 1'b1;
      idle       <= 1'b1;
      serial_out <= 1'b1;
`ifdef SER_XMT_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      idx        <= idx_n;
      tmr        <= tmr_n;
      len_m1     <= len_m1_n;
      count      <= count_n;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      ready      <= (count_n != FULL);
      idle       <= (state == S_IDLE) && !has_data;
      serial_out <= line;
`ifdef SER_XMT_PARITY_EN
      par        <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_ser_xmt.sv
// tb_ser_xmt: directed self-checking bench for ser_xmt.
// Line is sampled on the falling clock edge.

module tb_ser_xmt;

`ifdef SER_XMT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] bit_len;
  logic        write;
  logic [7:0]  data_in;
  logic        ready;
  logic        idle;
  logic        serial_out;

  int vectors;
  int miscompares;

  ser_xmt #(.DEPTH(4), .DEPTH_LG(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_len    (bit_len),
    .write      (write),
    .data_in    (data_in),
    .ready      (ready),
    .idle       (idle),
    .serial_out (serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: sim time expired, want finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst   = 1'b1;
    write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // decode one frame; waited = negedges until start bit seen
  task automatic rx_frame(input int len, output logic [7:0] b,
                          output logic p, output logic stp,
                          output int waited);
    waited = 0;
    b      = '0;
    p      = 1'b0;
    stp    = 1'b0;
    while (serial_out !== 1'b0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 2000) return;
    repeat (len / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (len) @(negedge clk);
      b[k] = serial_out;
    end
`ifdef SER_XMT_PARITY_EN
    repeat (len) @(negedge clk);
    p = serial_out;
`endif
    repeat (len) @(negedge clk);
    stp = serial_out;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    write = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({serial_out, ready, idle} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_out: line/ready/idle=%b want 111",
               {serial_out, ready, idle});
    end
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      vectors++;
      if ({serial_out, ready, idle} !== 3'b111) begin
        miscompares++;
        $display("FAIL reset_idle c=%0d: got %b want 111",
                 c, {serial_out, ready, idle});
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic       el;
    logic       ei;
    int         stop_at;
    int         idle_at;
    d       = 8'h55;
    stop_at = 6 + 32 + ((NB == 11) ? 4 : 0);
    idle_at = stop_at + 4;
    apply_reset();
    bit_len = 16'd4;
    data_in = d;
    write   = 1'b1;
    @(negedge clk);
    write = 1'b0;
    for (int c = 0; c <= idle_at + 3; c++) begin
      el = 1'b1;
      if (c >= 2 && c <= 5) el = 1'b0;
      else if (c >= 6 && c < 38) el = d[(c - 6) / 4];
      else if (c >= 38 && c < stop_at) el = ^d;
      ei = (c == 0) || (c >= idle_at);
      vectors++;
      if (serial_out !== el || idle !== ei || ready !== 1'b1) begin
        miscompares++;
        $display("FAIL single_55 c=%0d: line=%b idle=%b rdy=%b want %b %b 1",
                 c, serial_out, idle, ready, el, ei);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [5];
    logic [7:0] got [5];
    logic       s   [5];
    int         w   [5];
    logic       p;
    exp = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    apply_reset();
    bit_len = 16'd4;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          int g;
          g = 0;
          while (ready !== 1'b1 && g < 1000) begin
            @(negedge clk);
            g++;
          end
          data_in = exp[i];
          write   = 1'b1;
          @(negedge clk);
          write = 1'b0;
        end
        vectors++;
        if (ready !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_full: ready=%b want 0", ready);
        end
      end
      begin
        for (int i = 0; i < 5; i++) begin
          rx_frame(4, got[i], p, s[i], w[i]);
        end
      end
    join
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[i] || s[i] !== 1'b1 ||
          w[i] !== ((i == 0) ? 3 : 2)) begin
        miscompares++;
        $display("FAIL b2b_frame%0d: byte=%h stop=%b gap=%0d want %h 1 %0d",
                 i, got[i], s[i], w[i], exp[i], (i == 0) ? 3 : 2);
      end
    end
  endtask

  task automatic test_drop();
    logic [7:0] exp [5];
    logic [7:0] got [5];
    logic       s   [5];
    int         w   [5];
    logic       p;
    logic       low;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    apply_reset();
    bit_len = 16'd4;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          data_in = exp[i];
          write   = 1'b1;
          @(negedge clk);
        end
        write = 1'b0;
        vectors++;
        if (ready !== 1'b0) begin
          miscompares++;
          $display("FAIL drop_full: ready=%b want 0", ready);
        end
        data_in = 8'hEE;
        write   = 1'b1;
        @(negedge clk);
        write = 1'b0;
        vectors++;
        if (ready !== 1'b0) begin
          miscompares++;
          $display("FAIL drop_after: ready=%b want 0", ready);
        end
      end
      begin
        for (int i = 0; i < 5; i++) begin
          rx_frame(4, got[i], p, s[i], w[i]);
        end
      end
    join
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[i] || s[i] !== 1'b1 ||
          w[i] !== ((i == 0) ? 3 : 2)) begin
        miscompares++;
        $display("FAIL drop_frame%0d: byte=%h stop=%b gap=%0d want %h 1 %0d",
                 i, got[i], s[i], w[i], exp[i], (i == 0) ? 3 : 2);
      end
    end
    low = 1'b0;
    for (int c = 0; c < 3 * NB * 4; c++) begin
      @(negedge clk);
      if (serial_out !== 1'b1) low = 1'b1;
    end
    vectors++;
    if (low !== 1'b0 || idle !== 1'b1 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_tail: extra_frame=%b idle=%b rdy=%b want 0 1 1",
               low, idle, ready);
    end
  endtask

  task automatic test_bit_len_change();
    logic [7:0] got [2];
    logic       s   [2];
    int         w   [2];
    logic       p;
    apply_reset();
    bit_len = 16'd4;
    fork
      begin
        data_in = 8'h0F;
        write   = 1'b1;
        @(negedge clk);
        data_in = 8'h33;
        @(negedge clk);
        write = 1'b0;
        repeat (10) @(negedge clk);
        bit_len = 16'd8;
      end
      begin
        rx_frame(4, got[0], p, s[0], w[0]);
        rx_frame(8, got[1], p, s[1], w[1]);
      end
    join
    vectors++;
    if (got[0] !== 8'h0F || s[0] !== 1'b1 || w[0] !== 3) begin
      miscompares++;
      $display("FAIL len_frame0: byte=%h stop=%b gap=%0d want 0f 1 3",
               got[0], s[0], w[0]);
    end
    vectors++;
    if (got[1] !== 8'h33 || s[1] !== 1'b1 || w[1] !== 2) begin
      miscompares++;
      $display("FAIL len_frame1: byte=%h stop=%b gap=%0d want 33 1 2",
               got[1], s[1], w[1]);
    end
    bit_len = 16'd4;
  endtask

  task automatic test_mid_reset();
    logic low;
    apply_reset();
    bit_len = 16'd4;
    data_in = 8'h00;
    write   = 1'b1;
    @(negedge clk);
    data_in = 8'h11;
    @(negedge clk);
    data_in = 8'h22;
    @(negedge clk);
    write = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (serial_out !== 1'b0 || idle !== 1'b0) begin
      miscompares++;
      $display("FAIL mrst_pre: line=%b idle=%b want 0 0", serial_out, idle);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({serial_out, ready, idle} !== 3'b111) begin
      miscompares++;
      $display("FAIL mrst_abort: line/ready/idle=%b want 111",
               {serial_out, ready, idle});
    end
    rst = 1'b0;
    low = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || idle !== 1'b1) low = 1'b1;
    end
    vectors++;
    if (low !== 1'b0) begin
      miscompares++;
      $display("FAIL mrst_flush: queued data sent=%b want 0", low);
    end
  endtask

`ifdef SER_XMT_PARITY_EN
  task automatic test_parity();
    logic [7:0] got [2];
    logic       p   [2];
    logic       s   [2];
    int         w   [2];
    apply_reset();
    bit_len = 16'd4;
    fork
      begin
        data_in = 8'h07;
        write   = 1'b1;
        @(negedge clk);
        data_in = 8'h03;
        @(negedge clk);
        write = 1'b0;
      end
      begin
        rx_frame(4, got[0], p[0], s[0], w[0]);
        rx_frame(4, got[1], p[1], s[1], w[1]);
      end
    join
    vectors++;
    if (got[0] !== 8'h07 || p[0] !== 1'b1 || s[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL par_07: byte=%h par=%b stop=%b want 07 1 1",
               got[0], p[0], s[0]);
    end
    vectors++;
    if (got[1] !== 8'h03 || p[1] !== 1'b0 || w[1] !== 2) begin
      miscompares++;
      $display("FAIL par_03: byte=%h par=%b gap=%0d want 03 0 2",
               got[1], p[1], w[1]);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    write       = 1'b0;
    data_in     = '0;
    bit_len     = 16'd4;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_bit_len_change();
    test_mid_reset();
`ifdef SER_XMT_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
